// File: rtl/seq_mux_scan.sv
// Registered N:1 multiplexer with valid/ready output stage and an auto-scan mode.
// Optional even-parity output enabled by defining SEQ_MUX_PARITY_EN.
module seq_mux_scan #(
  parameter  int NUM_IN = 8,
  parameter  int DATA_W = 1,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_IN*DATA_W-1:0] data_in,
  input  logic [SEL_W-1:0]         sel_in,
  input  logic                     mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     sel_err,
  output logic                     scan_wrap
`ifdef SEQ_MUX_PARITY_EN
  ,
  output logic                     out_parity
`endif
);

  localparam int unsigned          N        = NUM_IN;
  localparam logic [SEL_W-1:0]     LAST_SEL = SEL_W'(NUM_IN - 1);

  logic              accept;
  logic [SEL_W-1:0]  scan_cnt;
  logic [SEL_W-1:0]  eff_sel;
  logic              sel_ok;
  logic [DATA_W-1:0] mux_val;
  logic [DATA_W-1:0] load_val;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign eff_sel  = mode ? scan_cnt : sel_in;
  assign sel_ok   = 32'(eff_sel) < N;

  always_comb begin
    mux_val = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (32'(eff_sel) == k) mux_val = data_in[k*DATA_W +: DATA_W];
    end
  end

  assign load_val = sel_ok ? mux_val : '0;

  // Counter is pinned to 0 outside scan mode so each scan sweep restarts at channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
    end else if (!mode) begin
      scan_cnt <= '0;
    end else if (accept) begin
      scan_cnt <= (scan_cnt == LAST_SEL) ? '0 : scan_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
      scan_wrap <= 1'b0;
    end else if (accept) begin
      out_data  <= load_val;
      out_sel   <= eff_sel;
      out_valid <= 1'b1;
      sel_err   <= !sel_ok;
      scan_wrap <= mode && (scan_cnt == LAST_SEL);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef SEQ_MUX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_parity <= 1'b0;
    end else if (accept) begin
      out_parity <= ^load_val;
    end
  end
`endif

endmodule

// File: tb/tb_seq_mux_scan.sv
// Directed bench for seq_mux_scan: 8x1 instance (direct/scan/backpressure/reset),
// 5x4 instance (illegal select, odd-size scan), optional 8x8 parity instance.
module tb_seq_mux_scan;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: NUM_IN=8, DATA_W=1
  logic [7:0] a_din;
  logic [2:0] a_sel, a_osel;
  logic a_mode, a_iv, a_ir, a_odata, a_ov, a_or, a_err, a_wrap;

  seq_mux_scan #(.NUM_IN(8), .DATA_W(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .data_in(a_din), .sel_in(a_sel), .mode(a_mode),
    .in_valid(a_iv), .in_ready(a_ir), .out_data(a_odata), .out_sel(a_osel),
    .out_valid(a_ov), .out_ready(a_or), .sel_err(a_err), .scan_wrap(a_wrap)
`ifdef SEQ_MUX_PARITY_EN
    , .out_parity()
`endif
  );

  // Instance B: NUM_IN=5, DATA_W=4
  logic [19:0] b_din;
  logic [2:0]  b_sel, b_osel;
  logic [3:0]  b_odata;
  logic b_mode, b_iv, b_ir, b_ov, b_or, b_err, b_wrap;

  seq_mux_scan #(.NUM_IN(5), .DATA_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .data_in(b_din), .sel_in(b_sel), .mode(b_mode),
    .in_valid(b_iv), .in_ready(b_ir), .out_data(b_odata), .out_sel(b_osel),
    .out_valid(b_ov), .out_ready(b_or), .sel_err(b_err), .scan_wrap(b_wrap)
`ifdef SEQ_MUX_PARITY_EN
    , .out_parity()
`endif
  );

`ifdef SEQ_MUX_PARITY_EN
  // Instance C: NUM_IN=8, DATA_W=8 with parity
  logic [63:0] c_din;
  logic [2:0]  c_sel, c_osel;
  logic [7:0]  c_odata;
  logic c_mode, c_iv, c_ir, c_ov, c_or, c_err, c_wrap, c_par;

  seq_mux_scan #(.NUM_IN(8), .DATA_W(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .data_in(c_din), .sel_in(c_sel), .mode(c_mode),
    .in_valid(c_iv), .in_ready(c_ir), .out_data(c_odata), .out_sel(c_osel),
    .out_valid(c_ov), .out_ready(c_or), .sel_err(c_err), .scan_wrap(c_wrap),
    .out_parity(c_par)
  );
`endif

  typedef struct {
    logic       mode;
    logic [2:0] sel;
    logic       iv;
    logic       ordy;
    logic [7:0] din;
    logic       ev;
    logic       ed;
    logic [2:0] es;
    logic       ew;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic ev, input logic ed,
                       input logic [2:0] es, input logic ew);
    chk({tag, ".valid"}, 64'(a_ov), 64'(ev));
    chk({tag, ".data"},  64'(a_odata), 64'(ed));
    chk({tag, ".sel"},   64'(a_osel), 64'(es));
    chk({tag, ".err"},   64'(a_err), 64'd0);
    chk({tag, ".wrap"},  64'(a_wrap), 64'(ew));
  endtask

  task automatic chk_b(input string tag, input logic ev, input logic [3:0] ed,
                       input logic [2:0] es, input logic ee, input logic ew);
    chk({tag, ".valid"}, 64'(b_ov), 64'(ev));
    chk({tag, ".data"},  64'(b_odata), 64'(ed));
    chk({tag, ".sel"},   64'(b_osel), 64'(es));
    chk({tag, ".err"},   64'(b_err), 64'(ee));
    chk({tag, ".wrap"},  64'(b_wrap), 64'(ew));
  endtask

  initial begin
    // Direct: 8'b1010_0110 -> ch1=1, ch3=0
    tbl[0]  = '{1'b0, 3'd1, 1'b1, 1'b1, 8'hA6, 1'b1, 1'b1, 3'd1, 1'b0};
    tbl[1]  = '{1'b0, 3'd3, 1'b1, 1'b1, 8'hA6, 1'b1, 1'b0, 3'd3, 1'b0};
    // Scan over 8'hA5: bits 0..7 = 1,0,1,0,0,1,0,1 then wrap to ch0=1
    tbl[2]  = '{1'b1, 3'd0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 3'd0, 1'b0};
    tbl[3]  = '{1'b1, 3'd0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 3'd1, 1'b0};
    tbl[4]  = '{1'b1, 3'd0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 3'd2, 1'b0};
    tbl[5]  = '{1'b1, 3'd0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 3'd3, 1'b0};
    tbl[6]  = '{1'b1, 3'd0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 3'd4, 1'b0};
    tbl[7]  = '{1'b1, 3'd0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 3'd5, 1'b0};
    tbl[8]  = '{1'b1, 3'd0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 3'd6, 1'b0};
    tbl[9]  = '{1'b1, 3'd0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 3'd7, 1'b1};
    tbl[10] = '{1'b1, 3'd0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 3'd0, 1'b0};
    // Idle drain: valid drops, data/sel hold
    tbl[11] = '{1'b0, 3'd0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 3'd0, 1'b0};

    a_din = '0; a_sel = '0; a_mode = 1'b0; a_iv = 1'b0; a_or = 1'b1;
    b_din = 20'h54C21; b_sel = '0; b_mode = 1'b0; b_iv = 1'b0; b_or = 1'b1;
`ifdef SEQ_MUX_PARITY_EN
    c_din = {48'h0, 8'h33, 8'hB3}; c_sel = '0; c_mode = 1'b0; c_iv = 1'b0; c_or = 1'b1;
`endif

    // Reset state
    #12;
    chk_a("reset_a", 1'b0, 1'b0, 3'd0, 1'b0);
    chk_b("reset_b", 1'b0, 4'h0, 3'd0, 1'b0, 1'b0);
    chk("reset_in_ready", 64'(a_ir), 64'd1);
`ifdef SEQ_MUX_PARITY_EN
    chk("reset_parity", 64'(c_par), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Table: direct, scan sweep with wrap, idle drain
    for (int i = 0; i < 12; i++) begin
      a_mode = tbl[i].mode; a_sel = tbl[i].sel; a_iv = tbl[i].iv;
      a_or = tbl[i].ordy; a_din = tbl[i].din;
      step();
      chk_a($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].es, tbl[i].ew);
    end

    // Backpressure: load ch5 of A5 (=1), then stall 4 cycles while inputs churn
    a_mode = 1'b0; a_sel = 3'd5; a_iv = 1'b1; a_or = 1'b1; a_din = 8'hA5;
    step();
    chk_a("bp_load", 1'b1, 1'b1, 3'd5, 1'b0);
    a_or = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_sel = 3'(i);
      a_din = 8'(i * 8'h11);
      #1;
      chk("bp_in_ready", 64'(a_ir), 64'd0);
      step();
      chk_a($sformatf("bp_stall%0d", i), 1'b1, 1'b1, 3'd5, 1'b0);
    end
    a_or = 1'b1; a_sel = 3'd6; a_din = 8'h40;
    #1;
    chk("bp_release_ready", 64'(a_ir), 64'd1);
    step();
    chk_a("bp_release", 1'b1, 1'b1, 3'd6, 1'b0);
    a_sel = 3'd0;
    step();
    chk_a("bp_no_bubble", 1'b1, 1'b0, 3'd0, 1'b0);
    a_iv = 1'b0;
    step();
    chk_a("bp_drain", 1'b0, 1'b0, 3'd0, 1'b0);

    // Instance B: ch0..4 = 1,2,C,4,5
    b_iv = 1'b1; b_sel = 3'd6;
    step();
    chk_b("err_sel6", 1'b1, 4'h0, 3'd6, 1'b1, 1'b0);
    b_sel = 3'd2;
    step();
    chk_b("err_clear", 1'b1, 4'hC, 3'd2, 1'b0, 1'b0);
    b_sel = 3'd5;
    step();
    chk_b("err_sel5", 1'b1, 4'h0, 3'd5, 1'b1, 1'b0);
    b_mode = 1'b1;
    step();
    chk_b("scan5_0", 1'b1, 4'h1, 3'd0, 1'b0, 1'b0);
    step();
    chk_b("scan5_1", 1'b1, 4'h2, 3'd1, 1'b0, 1'b0);
    step();
    chk_b("scan5_2", 1'b1, 4'hC, 3'd2, 1'b0, 1'b0);
    step();
    chk_b("scan5_3", 1'b1, 4'h4, 3'd3, 1'b0, 1'b0);
    step();
    chk_b("scan5_4", 1'b1, 4'h5, 3'd4, 1'b0, 1'b1);
    b_iv = 1'b0;
    step();
    chk_b("scan5_hold", 1'b0, 4'h5, 3'd4, 1'b0, 1'b1);
    b_iv = 1'b1;
    step();
    chk_b("scan5_wrap0", 1'b1, 4'h1, 3'd0, 1'b0, 1'b0);
    b_mode = 1'b0; b_sel = 3'd1;
    step();
    chk_b("direct_after_scan", 1'b1, 4'h2, 3'd1, 1'b0, 1'b0);
    b_iv = 1'b0;

`ifdef SEQ_MUX_PARITY_EN
    c_iv = 1'b1; c_sel = 3'd0;
    step();
    chk("par_b3", 64'(c_par), 64'd1);
    chk("par_b3_data", 64'(c_odata), 64'hB3);
    c_or = 1'b0; c_sel = 3'd1;
    step();
    chk("par_stall", 64'(c_par), 64'd1);
    c_or = 1'b1;
    step();
    chk("par_33", 64'(c_par), 64'd0);
    chk("par_33_data", 64'(c_odata), 64'h33);
    c_iv = 1'b0;
`endif

    // Reset mid-scan: five accepts leave counter at 5
    a_mode = 1'b1; a_iv = 1'b1; a_or = 1'b1; a_din = 8'hA5;
    for (int i = 0; i < 5; i++) step();
    chk_a("prerst", 1'b1, 1'b0, 3'd4, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_a("midrst", 1'b0, 1'b0, 3'd0, 1'b0);
    #1 rst_n = 1'b1;
    step();
    chk_a("postrst0", 1'b1, 1'b1, 3'd0, 1'b0);
    step();
    chk_a("postrst1", 1'b1, 1'b0, 3'd1, 1'b0);
    a_iv = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_mux_scan.md
Name: seq_mux_scan

Overview:
- Parametrised, registered N:1 multiplexer with a valid/ready handshake; next generation of the team's combinational 8:1 single-bit mux benchmark.
- Generalised in channel count and data width.
- Adds an output pipeline register with backpressure and an auto-scan mode in which an internal counter sweeps all channels.
- Sits between a bank of parallel sources and a single serial consumer.

Parameters:
- NUM_IN, 8, number of input channels; legal range 2..256, need not be a power of two.
- DATA_W, 1, width of each channel in bits; legal range 1..64.
- SEL_W, $clog2(NUM_IN), select width; derived localparam, not overridable.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  NUM_IN*DATA_W  channel k occupies data_in[k*DATA_W +: DATA_W].
- sel_in  in  SEL_W  channel select, used in direct mode only.
- mode  in  1  0 = direct, 1 = scan.
- in_valid  in  1  request to sample data_in.
- in_ready  out  1  block can accept a sample this cycle.
- out_data  out  DATA_W  registered selected channel.
- out_sel  out  SEL_W  channel index that produced out_data.
- out_valid  out  1  out_data/out_sel valid.
- out_ready  in  1  consumer accepts output this cycle.
- sel_err  out  1  registered; set when the sampled select was >= NUM_IN.
- scan_wrap  out  1  registered; high alongside the output of the last channel of a scan sweep.

Behaviour:
- Reset (rst_n low, asynchronous): out_data=0, out_sel=0, out_valid=0, sel_err=0, scan_wrap=0, scan counter=0. Reset mid-transfer drops the held output; nothing is replayed.
- in_ready is combinational: in_ready = !out_valid || out_ready.
- Accept occurs when in_valid && in_ready. Latency is 1 cycle from accept to out_valid.
- Effective select: sel_in when mode=0; scan counter when mode=1.
- On accept:
  - out_data <= channel[eff_sel]; out_sel <= eff_sel; out_valid <= 1.
  - If eff_sel >= NUM_IN (only possible in direct mode with a non-power-of-two NUM_IN): out_data <= 0 and sel_err <= 1. Otherwise sel_err <= 0.
- No accept and out_ready=1: out_valid <= 0. out_data, out_sel and sel_err hold.
- No accept and out_ready=0: all outputs hold. The output register is stable while stalled.
- Simultaneous drain and accept (out_valid=1, out_ready=1, in_valid=1): the new sample replaces the old one in the same edge. Full throughput is 1 sample per cycle.
- Scan counter:
  - Advances only on accept in mode=1.
  - Counts 0,1,...,NUM_IN-1, then wraps to 0.
  - scan_wrap <= 1 on the accept that samples index NUM_IN-1; scan_wrap <= 0 on any other accept. Holds otherwise.
- Mode switching:
  - While mode=0 the scan counter is forced to 0, so every entry to scan mode starts at channel 0.
  - A mode change takes effect on the next accept; a held output is not modified.
  - In direct mode scan_wrap is always written 0 on accept.
- No combinational path from data_in or sel_in to any output. The only combinational output path is out_ready -> in_ready.

Optional Feature:
- Macro: SEQ_MUX_PARITY_EN.
- When defined:
  - Adds output port out_parity (1 bit) = registered even parity (XOR reduction) of the value loaded into out_data, updated on the same edge as out_data.
  - Reset value is 0; it holds under stall.
  - On sel_err the loaded value is 0, so out_parity=0.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
1. NUM_IN=8, DATA_W=1, data_in=8'b1010_0110, mode=0, sel_in=1 then 3, in_valid=1, out_ready=1 -> out_data=1, out_sel=1 one cycle after first accept; next cycle out_data=0, out_sel=3; sel_err=0 throughout.
2. Scan: NUM_IN=8, data_in=8'hA5, mode=1, in_valid=1, out_ready=1 for 9 cycles -> out_sel sequence 0..7,0; out_data 1,0,1,0,0,1,0,1,1; scan_wrap high only with out_sel=7.
3. Backpressure: out_valid=1 with out_ready=0 for 4 cycles while data_in/sel_in change -> in_ready=0, outputs frozen. Release out_ready with in_valid=1 -> new sample appears next cycle with no bubble.
4. Error select: NUM_IN=5, DATA_W=4, sel_in=6 accepted -> out_data=4'h0, out_sel=6, sel_err=1. Next accept with sel_in=2 -> sel_err=0, out_data=channel 2.
5. Reset mid-scan: scan counter at 5, out_valid=1, pulse rst_n low asynchronously (between edges) -> all outputs 0 immediately. After release, first scan accept yields out_sel=0.
6. With SEQ_MUX_PARITY_EN: DATA_W=8, channel 0=8'hB3, accept sel 0 -> out_parity=1. Channel 1=8'h33, accept sel 1 -> out_parity=0.
